// File: rtl/game_round_scheduler.sv
// Game progression sequencer: start, countdown, per-frame wall depth stepping, judging, score/lives/speed.
// Optional GAME_RANDOM_WALL_ORDER_EN selects the next wall from a 16-bit LFSR instead of in order.
module game_round_scheduler #(
    parameter int unsigned NUM_WALLS                = 10,
    parameter int unsigned MAX_FRAMES_PER_WALL_TICK = 15,
    parameter int unsigned MIN_FRAMES_PER_WALL_TICK = 2,
    parameter int unsigned SPEEDUP_ROUNDS           = 3,
    parameter int unsigned MAX_WALL_DEPTH           = 75,
    parameter int unsigned GOAL_DEPTH_MIN           = 50,
    parameter int unsigned GOAL_DEPTH_MAX           = 70,
    parameter int unsigned COLLISION_THRESHOLD      = 16,
    parameter int unsigned START_LIVES              = 3,
    parameter int unsigned COUNTDOWN_FRAMES         = 180,
    parameter int unsigned RESULT_FRAMES            = 60
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        new_frame_in,
    input  logic        collision_in,
    input  logic        pixel_valid_in,
    output logic [7:0]  wall_depth_out,
    output logic [3:0]  wall_idx_out,
    output logic [3:0]  frames_per_tick_out,
    output logic [7:0]  round_out,
    output logic [15:0] score_out,
    output logic [1:0]  lives_out,
    output logic        round_result_out,
    output logic [2:0]  game_state_out
);

    localparam int unsigned PIX_W = $clog2(COLLISION_THRESHOLD) + 1;
    localparam int unsigned SPD_W = $clog2(SPEEDUP_ROUNDS + 1);

    localparam logic [7:0]       CD_LAST    = 8'(COUNTDOWN_FRAMES - 1);
    localparam logic [7:0]       RES_LAST   = 8'(RESULT_FRAMES - 1);
    localparam logic [7:0]       DEPTH_LAST = 8'(MAX_WALL_DEPTH - 1);
    localparam logic [7:0]       GOAL_MIN   = 8'(GOAL_DEPTH_MIN);
    localparam logic [7:0]       GOAL_MAX   = 8'(GOAL_DEPTH_MAX);
    localparam logic [3:0]       WALL_LAST  = 4'(NUM_WALLS - 1);
    localparam logic [3:0]       FPT_MAX    = 4'(MAX_FRAMES_PER_WALL_TICK);
    localparam logic [3:0]       FPT_MIN    = 4'(MIN_FRAMES_PER_WALL_TICK);
    localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);
    localparam logic [PIX_W-1:0] PIX_THR    = PIX_W'(COLLISION_THRESHOLD);
    localparam logic [SPD_W-1:0] SPD_LAST   = SPD_W'(SPEEDUP_ROUNDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAYING   = 3'd2,
        ST_RESULT    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        depth_q, depth_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        fpt_q, fpt_d;
    logic [7:0]        round_q, round_d;
    logic [15:0]       score_q, score_d;
    logic [1:0]        lives_q, lives_d;
    logic              result_q, result_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [3:0]        tick_q, tick_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              fail_q, fail_d;
    logic [SPD_W-1:0]  pass_cnt_q, pass_cnt_d;

    logic             hit;
    logic [PIX_W-1:0] pix_sum;
    logic             fail_now;
    logic [3:0]       idx_inc;
    logic [3:0]       idx_next;

    assign idx_inc = (idx_q == WALL_LAST) ? '0 : idx_q + 4'd1;

`ifdef GAME_RANDOM_WALL_ORDER_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  idx_rnd;

    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign idx_rnd  = 4'(32'(lfsr_q[3:0]) % NUM_WALLS);
    assign idx_next = (idx_rnd == idx_q) ? idx_inc : idx_rnd;

    always_ff @(posedge clk_in) begin
        if (!rst_in) lfsr_q <= 16'hACE1;
        else         lfsr_q <= lfsr_d;
    end
`else
    assign idx_next = idx_inc;
`endif

    // A pixel coinciding with new_frame belongs to the frame being closed.
    assign hit      = pixel_valid_in & collision_in & (depth_q >= GOAL_MIN) & (depth_q <= GOAL_MAX);
    assign pix_sum  = (pix_q == '1) ? pix_q : pix_q + PIX_W'(hit);
    assign fail_now = fail_q | (pix_sum >= PIX_THR);

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        idx_d       = idx_q;
        fpt_d       = fpt_q;
        round_d     = round_q;
        score_d     = score_q;
        lives_d     = lives_q;
        result_d    = result_q;
        frame_cnt_d = frame_cnt_q;
        tick_d      = tick_q;
        pix_d       = pix_q;
        fail_d      = fail_q;
        pass_cnt_d  = pass_cnt_q;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_in) begin
                    state_d     = ST_COUNTDOWN;
                    score_d     = '0;
                    lives_d     = LIVES_INIT;
                    round_d     = '0;
                    idx_d       = '0;
                    fpt_d       = FPT_MAX;
                    frame_cnt_d = '0;
                    pass_cnt_d  = '0;
                end
            end
            ST_COUNTDOWN: begin
                if (new_frame_in) begin
                    if (frame_cnt_q == CD_LAST) begin
                        state_d     = ST_PLAYING;
                        frame_cnt_d = '0;
                        round_d     = (round_q == '1) ? round_q : round_q + 8'd1;
                        depth_d     = '0;
                        tick_d      = '0;
                        pix_d       = '0;
                        fail_d      = 1'b0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            ST_PLAYING: begin
                pix_d = pix_sum;
                if (new_frame_in) begin
                    pix_d  = '0;
                    fail_d = fail_now;
                    if (tick_q == fpt_q - 4'd1) begin
                        tick_d = '0;
                        if (depth_q == DEPTH_LAST) begin
                            state_d     = ST_RESULT;
                            result_d    = ~fail_now;
                            frame_cnt_d = '0;
                            idx_d       = idx_next;
                            if (!fail_now) begin
                                score_d = (score_q == '1) ? score_q : score_q + 16'd1;
                                if (pass_cnt_q == SPD_LAST) begin
                                    pass_cnt_d = '0;
                                    fpt_d      = (fpt_q > FPT_MIN) ? fpt_q - 4'd1 : fpt_q;
                                end else begin
                                    pass_cnt_d = pass_cnt_q + SPD_W'(1);
                                end
                            end else if (lives_q != '0) begin
                                lives_d = lives_q - 2'd1;
                            end
                        end else begin
                            depth_d = depth_q + 8'd1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            ST_RESULT: begin
                if (new_frame_in) begin
                    if (frame_cnt_q == RES_LAST) begin
                        frame_cnt_d = '0;
                        state_d     = (lives_q == '0) ? ST_GAME_OVER : ST_COUNTDOWN;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            depth_q     <= '0;
            idx_q       <= '0;
            fpt_q       <= FPT_MAX;
            round_q     <= '0;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            result_q    <= 1'b0;
            frame_cnt_q <= '0;
            tick_q      <= '0;
            pix_q       <= '0;
            fail_q      <= 1'b0;
            pass_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            idx_q       <= idx_d;
            fpt_q       <= fpt_d;
            round_q     <= round_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            result_q    <= result_d;
            frame_cnt_q <= frame_cnt_d;
            tick_q      <= tick_d;
            pix_q       <= pix_d;
            fail_q      <= fail_d;
            pass_cnt_q  <= pass_cnt_d;
        end
    end

    assign wall_depth_out      = depth_q;
    assign wall_idx_out        = idx_q;
    assign frames_per_tick_out = fpt_q;
    assign round_out           = round_q;
    assign score_out           = score_q;
    assign lives_out           = lives_q;
    assign round_result_out    = result_q;
    assign game_state_out      = state_q;

endmodule

// File: tb/tb_game_round_scheduler.sv
// Randomized bench for game_round_scheduler against a frame-level reference model of the game rules.
module tb_game_round_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic        new_frame_in;
    logic        collision_in;
    logic        pixel_valid_in;
    logic [7:0]  wall_depth_out;
    logic [3:0]  wall_idx_out;
    logic [3:0]  frames_per_tick_out;
    logic [7:0]  round_out;
    logic [15:0] score_out;
    logic [1:0]  lives_out;
    logic        round_result_out;
    logic [2:0]  game_state_out;

    always #5 clk_in = ~clk_in;

    game_round_scheduler dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .start_in            (start_in),
        .new_frame_in        (new_frame_in),
        .collision_in        (collision_in),
        .pixel_valid_in      (pixel_valid_in),
        .wall_depth_out      (wall_depth_out),
        .wall_idx_out        (wall_idx_out),
        .frames_per_tick_out (frames_per_tick_out),
        .round_out           (round_out),
        .score_out           (score_out),
        .lives_out           (lives_out),
        .round_result_out    (round_result_out),
        .game_state_out      (game_state_out)
    );

    localparam int MODE_CLEAN = 0, MODE_NOISE15 = 1, MODE_EDGE = 2, MODE_FAIL = 3, MODE_RAND = 4;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: game rules expressed per frame, depth derived from frames elapsed.
    int m_state, m_frames, m_depth, m_round, m_score, m_lives, m_result;
    int m_passes, m_judged, m_hits;
    bit m_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_fpt();
        int f;
        f = 15 - m_passes / 3;
        return (f < 2) ? 2 : f;
    endfunction

    function automatic bit in_win(input int d);
        return d >= 50 && d <= 70;
    endfunction

    function automatic void model_reset();
        m_state = 0; m_frames = 0; m_depth = 0; m_round = 0; m_score = 0;
        m_lives = 3; m_result = 0; m_passes = 0; m_judged = 0; m_hits = 0; m_fail = 0;
    endfunction

    function automatic void model_start();
        m_state = 1; m_frames = 0; m_round = 0; m_score = 0; m_lives = 3;
        m_passes = 0; m_judged = 0;
    endfunction

    function automatic void model_frame(input bit hit_now);
        case (m_state)
            1: begin
                m_frames++;
                if (m_frames == 180) begin
                    m_state = 2; m_frames = 0; m_depth = 0; m_fail = 0; m_hits = 0;
                    m_round = (m_round < 255) ? m_round + 1 : 255;
                end
            end
            2: begin
                m_hits += int'(hit_now);
                if (m_hits >= 16) m_fail = 1;
                m_hits = 0;
                m_frames++;
                if (m_frames == 75 * m_fpt()) begin
                    m_state = 3; m_frames = 0; m_result = int'(!m_fail); m_judged++;
                    if (!m_fail) begin
                        m_passes++;
                        m_score++;
                    end else begin
                        m_lives--;
                    end
                end else begin
                    m_depth = m_frames / m_fpt();
                end
            end
            3: begin
                m_frames++;
                if (m_frames == 60) begin
                    m_frames = 0;
                    m_state = (m_lives == 0) ? 4 : 1;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic check_all();
        check("state", 32'(game_state_out), m_state);
        check("depth", 32'(wall_depth_out), m_depth);
        check("wall_idx", 32'(wall_idx_out), m_judged % 10);
        check("fpt", 32'(frames_per_tick_out), m_fpt());
        check("round", 32'(round_out), m_round);
        check("score", 32'(score_out), m_score);
        check("lives", 32'(lives_out), m_lives);
        if (m_state == 3) check("result", 32'(round_result_out), m_result);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        start_in = 0; new_frame_in = 0; collision_in = 0; pixel_valid_in = 0;
    endtask

    task automatic pix_cycle(input bit v, input bit c);
        pixel_valid_in = v; collision_in = c;
        step();
        if (m_state == 2 && v && c && in_win(m_depth)) m_hits++;
        idle_inputs();
    endtask

    task automatic frame(input bit v, input bit c);
        bit hit;
        hit = (m_state == 2) && v && c && in_win(m_depth);
        new_frame_in = 1; pixel_valid_in = v; collision_in = c;
        step();
        model_frame(hit);
        idle_inputs();
        check_all();
    endtask

    task automatic start_pulse();
        start_in = 1;
        step();
        if (m_state == 0 || m_state == 4) model_start();
        idle_inputs();
        check_all();
    endtask

    task automatic do_reset(input int n);
        idle_inputs();
        rst_in = 0;
        repeat (n) step();
        rst_in = 1;
        model_reset();
        check_all();
    endtask

    // n collision pixels in one frame, mixed with non-colliding pixel cycles.
    task automatic frame_hits(input int n);
        bit coincide;
        int k;
        coincide = (n > 0) && ($urandom % 2 == 1);
        k = coincide ? n - 1 : n;
        for (int i = 0; i < k; i++) begin
            if ($urandom % 4 == 0) begin
                bit v;
                v = 1'($urandom % 2);
                pix_cycle(v, ~v);
            end
            pix_cycle(1, 1);
        end
        frame(coincide, coincide);
    endtask

    task automatic run_countdown();
        for (int g = 0; g < 400 && m_state == 1; g++) begin
            if ($urandom % 64 == 0) start_pulse();
            frame(0, 0);
        end
    endtask

    task automatic run_playing(input int mode, input int fdepth, input int stop_depth);
        for (int g = 0; g < 3000 && m_state == 2; g++) begin
            bit first;
            int d;
            if (stop_depth >= 0 && m_depth == stop_depth) return;
            d = m_depth;
            first = (m_frames % m_fpt()) == 0;
            if ($urandom % 128 == 0) start_pulse();
            case (mode)
                MODE_NOISE15: if (first && in_win(d)) frame_hits(15); else frame(0, 0);
                MODE_EDGE: begin
                    if (first && (d == 49 || d == 71)) frame_hits(100);
                    else if (first && in_win(d) && $urandom % 2 == 1) frame_hits($urandom_range(0, 15));
                    else frame(0, 0);
                end
                MODE_FAIL: if (first && d == fdepth) frame_hits(16); else frame(0, 0);
                MODE_RAND: if (first && $urandom % 2 == 1) frame_hits($urandom_range(0, 15)); else frame(0, 0);
                default: frame(0, 0);
            endcase
        end
    endtask

    task automatic run_result();
        for (int g = 0; g < 200 && m_state == 3; g++) begin
            if ($urandom % 32 == 0) start_pulse();
            frame(0, 0);
        end
    endtask

    task automatic play_round(input int mode, input int fdepth);
        run_countdown();
        run_playing(mode, fdepth, -1);
        run_result();
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        rst_in = 1;
        idle_inputs();
        model_reset();
        do_reset(3);
        start_pulse();

        play_round(MODE_CLEAN, 0);
        play_round(MODE_NOISE15, 0);
        play_round(MODE_EDGE, 0);
        play_round(MODE_FAIL, 50);
        for (int r = 5; r <= 44; r++) play_round((r % 2 == 1) ? MODE_RAND : MODE_CLEAN, 0);
        play_round(MODE_FAIL, $urandom_range(50, 70));
        play_round(MODE_FAIL, 70);

        repeat (5) frame(0, 0);
        start_pulse();
        run_countdown();
        run_playing(MODE_RAND, 0, 40);
        do_reset(1);
        repeat (3) frame(0, 0);
        start_pulse();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
